cpu_step_sequencer: RTL and testbench
=====================================

Name: cpu_step_sequencer

Overview:
- Controls CPU clock-enable for debug stepping: free run, halt, or a burst of T-state or whole-instruction steps per debounced press of the front-panel step key.
- Sits between the clock generator's per-T-state slot strobe and the CPU clock-enable input.
- Drives the halted status to the OSD/LEDs.

Parameters:
DEBOUNCE_CYCLES, 24000, clk24 cycles the synchronized key must stay stable before it is accepted (1 ms)
CNT_W, 8, width of burst counter

Ports:
clk24  in  1  system clock, 24 MHz
reset  in  1  synchronous, active-high
ce_slot  in  1  one-clk24 pulse per CPU T-state from the clock generator
step_enabled  in  1  1 = stepping mode, 0 = free run
step_instr  in  1  0 = step unit is one T-state, 1 = step unit is one instruction
n_key  in  1  step key, active-low, asynchronous
burst_len  in  CNT_W  step units per key press; 0 treated as 1
cpu_m1  in  1  CPU is in the opcode-fetch T-state; valid with ce_slot
cpu_ce  out  1  gated CPU clock-enable
halted  out  1  high in IDLE
busy  out  1  high in STEP
steps_left  out  CNT_W  remaining step units

Behaviour:
- Interface: one clock, clk24. Reset is synchronous, active-high, on port reset.
- Reset values: state RUN, cpu_ce 0 during the reset cycle, halted 0, busy 0, steps_left 0, debounced key 1, debounce counter 0, started 0.
- Key path:
  - 2-FF synchronizer on n_key.
  - Counter clears whenever the synchronized value equals the stable value.
  - Otherwise it increments. At DEBOUNCE_CYCLES-1 the stable value takes the synchronized value.
  - press = single-cycle pulse on a stable 1->0 transition.
  - A held key yields one press. The release must itself debounce before another press is possible.
- cpu_ce = ce_slot & grant. grant is combinational from the registered state, started, step_instr and cpu_m1, so latency from ce_slot is zero.
- FSM RUN:
  - grant = 1.
  - If step_enabled=1 and step_instr=0: go to IDLE next cycle.
  - If step_enabled=1 and step_instr=1: keep running until a ce_slot with cpu_m1=1. That slot is withheld (grant 0), then go to IDLE.
- FSM IDLE:
  - grant = 0, halted = 1.
  - step_enabled=0: go to RUN.
  - press: load steps_left = max(burst_len,1), started=0, go to STEP.
- FSM STEP, T-state mode (step_instr=0):
  - Every ce_slot is granted and decrements steps_left.
  - When steps_left goes 1->0: go to IDLE.
- FSM STEP, instruction mode (step_instr=1):
  - A ce_slot is granted unless cpu_m1=1 and started=1. A granted slot sets started.
  - A withheld slot (cpu_m1 & started) clears started and decrements steps_left; at 0 go to IDLE.
  - The CPU is frozen, so the next slot still shows cpu_m1=1 with started=0 and is granted as the first T-state of the next instruction.
- Mode change: step_instr is sampled only on the IDLE->STEP transition; later changes are ignored until the next burst.
- Presses during STEP or RUN are dropped, not queued.
- Abort: step_enabled=0 in STEP goes to RUN next cycle; steps_left clears.
- Simultaneous press and step_enabled=0 in IDLE: go to RUN; the press is dropped.
- A ce_slot coincident with the STEP->IDLE transition follows the STEP grant rule for that cycle.
- Reset mid-burst returns to RUN immediately.

Optional Feature:
STEP_BREAKPOINT_EN
- Present:
  - Adds ports bp_enable (in 1), bp_addr (in 16), cpu_addr (in 16), bp_hit (out 1).
  - In RUN with bp_enable=1, a ce_slot with cpu_m1=1 and cpu_addr==bp_addr is withheld and the FSM goes to IDLE.
  - bp_hit sets, is sticky, and clears on the next press or on reset.
  - A burst starting at the breakpoint address is not re-trapped on its first fetch: the trap is masked while started=0 after a press.
- Absent: no such ports; RUN never self-halts except through step_enabled.

Decomposition:
- Package step_pkg: state enum {RUN, IDLE, STEP}, default CNT_W, DEBOUNCE_CYCLES default.
- Sub-module key_debounce: synchronizer, counter and press pulse, parameterized by DEBOUNCE_CYCLES. The bench runs it with DEBOUNCE_CYCLES=4.

Test Plan:
- Free run: step_enabled=0, ce_slot every 8 cycles for 100 cycles -> cpu_ce identical to ce_slot, halted=0.
- T-state burst: step_enabled=1, step_instr=0, burst_len=3, one press -> exactly 3 cpu_ce pulses, then halted=1, steps_left=0. Holding the key 50 more cycles gives no further pulses.
- Instruction step: step_instr=1, burst_len=2, instruction lengths 4 and 7 T-states -> 11 granted slots. The M1 slot of the third instruction is withheld, then halted=1.
- Debounce: key bounces with 2-cycle glitches for 20 cycles, then stays low (DEBOUNCE_CYCLES=4) -> exactly one press, 3 cycles of stable-low plus 2 synchronizer cycles after the final edge.
- Abort: burst_len=200 and step_enabled dropped after 5 grants -> RUN next cycle, cpu_ce follows ce_slot, steps_left=0. burst_len=0 -> one step.
- STEP_BREAKPOINT_EN: bp_addr=0x0100, M1 at 0x0100 -> slot withheld, halted=1, bp_hit=1. The next press steps past it and clears bp_hit.

Source files
------------

// File: rtl/cpu_step_sequencer_pkg.sv
// step_pkg: shared state encoding and default parameters for cpu_step_sequencer.
package step_pkg;
    localparam int CNT_W_DEF = 8;
    localparam int DEBOUNCE_DEF = 24000;
    typedef enum logic [1:0] {RUN, IDLE, STEP} state_e;
endpackage

// File: rtl/cpu_step_sequencer_if.sv
// cpu_step_sequencer_if: slot strobe, CPU status, step key and status bundle.
// STEP_BREAKPOINT_EN adds the breakpoint compare signals.
interface cpu_step_sequencer_if import step_pkg::*; #(parameter int CNT_W = CNT_W_DEF) ();
    logic             ce_slot, step_enabled, step_instr, n_key, cpu_m1;
    logic             cpu_ce, halted, busy;
    logic [CNT_W-1:0] burst_len, steps_left;
`ifdef STEP_BREAKPOINT_EN
    logic             bp_enable, bp_hit;
    logic [15:0]      bp_addr, cpu_addr;
`endif
    modport master (
`ifdef STEP_BREAKPOINT_EN
        output bp_enable, bp_addr, cpu_addr, input bp_hit,
`endif
        output ce_slot, step_enabled, step_instr, n_key, cpu_m1, burst_len,
        input cpu_ce, halted, busy, steps_left
    );
    modport slave (
`ifdef STEP_BREAKPOINT_EN
        input bp_enable, bp_addr, cpu_addr, output bp_hit,
`endif
        input ce_slot, step_enabled, step_instr, n_key, cpu_m1, burst_len,
        output cpu_ce, halted, busy, steps_left
    );
endinterface

// File: rtl/cpu_step_sequencer_key_debounce.sv
// key_debounce: synchronizes the active-low step key, debounces it and emits
// a one-cycle press pulse on each accepted 1->0 transition.
module key_debounce import step_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk24,
    input  logic reset,
    input  logic n_key_i,
    output logic press_o
);
    localparam int W = $clog2(DEBOUNCE_CYCLES) + 1;
    logic [1:0]   sync_q;
    logic         stable_q, stable_d, press_q, press_d, differ, accept;
    logic [W-1:0] cnt_q, cnt_d;
    assign differ  = sync_q[1] != stable_q;
    assign accept  = differ && (cnt_q + 1'b1 == W'(DEBOUNCE_CYCLES - 1));
    assign press_o = press_q;
    always_comb begin
        cnt_d    = (differ && !accept) ? cnt_q + 1'b1 : '0;
        stable_d = accept ? sync_q[1] : stable_q;
        press_d  = accept & stable_q;
    end
    always_ff @(posedge clk24) begin
        if (reset) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], n_key_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end
endmodule

// File: rtl/cpu_step_sequencer.sv
// cpu_step_sequencer: gates the CPU clock-enable for free run, halt and key-driven
// T-state / instruction step bursts. STEP_BREAKPOINT_EN adds an M1 address breakpoint.
module cpu_step_sequencer import step_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic clk24,
    input logic reset,
    cpu_step_sequencer_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             started_q, started_d, instr_q, instr_d;
    logic             press, trap, run_hold, step_hold, grant;
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk24(clk24), .reset(reset), .n_key_i(bus.n_key), .press_o(press)
    );
`ifdef STEP_BREAKPOINT_EN
    logic bp_hit_q, bp_hit_d;
    // started masks the trap so a resumed burst can fetch at the breakpoint
    assign trap       = bus.bp_enable & bus.cpu_m1 & started_q & (bus.cpu_addr == bus.bp_addr);
    assign bp_hit_d   = (bp_hit_q | (state_q == RUN & bus.ce_slot & trap))
                        & ~(state_q == IDLE & bus.step_enabled & press);
    assign bus.bp_hit = bp_hit_q;
    always_ff @(posedge clk24) bp_hit_q <= reset ? 1'b0 : bp_hit_d;
`else
    assign trap = 1'b0;
`endif
    assign run_hold       = (bus.step_enabled & bus.step_instr & bus.cpu_m1) | trap;
    assign step_hold      = instr_q & bus.cpu_m1 & started_q;
    assign grant          = (state_q == RUN) ? ~run_hold : (state_q == STEP) ? ~step_hold : 1'b0;
    assign bus.cpu_ce     = bus.ce_slot & grant & ~reset;
    assign bus.halted     = state_q == IDLE;
    assign bus.busy       = state_q == STEP;
    assign bus.steps_left = steps_q;
    always_comb begin
        state_d   = state_q;
        steps_d   = steps_q;
        started_d = started_q;
        instr_d   = instr_q;
        unique case (state_q)
            RUN: begin
                started_d = started_q | (bus.ce_slot & grant);
                if ((bus.step_enabled & ~bus.step_instr) | (bus.ce_slot & run_hold)) state_d = IDLE;
            end
            IDLE: begin
                if (!bus.step_enabled) state_d = RUN;
                else if (press) begin
                    state_d   = STEP;
                    steps_d   = (bus.burst_len == '0) ? CNT_W'(1) : bus.burst_len;
                    started_d = 1'b0;
                    instr_d   = bus.step_instr;
                end
            end
            STEP: begin
                if (!bus.step_enabled) begin
                    state_d = RUN;
                    steps_d = '0;
                end else if (bus.ce_slot) begin
                    // a granted instruction-mode slot only marks the instruction as started
                    if (instr_q & ~step_hold) started_d = 1'b1;
                    else begin
                        started_d = 1'b0;
                        steps_d   = steps_q - 1'b1;
                        if (steps_q == CNT_W'(1)) state_d = IDLE;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge clk24) begin
        if (reset) begin
            state_q   <= RUN;
            steps_q   <= '0;
            started_q <= 1'b0;
            instr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            steps_q   <= steps_d;
            started_q <= started_d;
            instr_q   <= instr_d;
        end
    end
endmodule

// File: tb/tb_cpu_step_sequencer.sv
// tb_cpu_step_sequencer: vector table, directed step/debounce/abort sequences and
// randomized bursts scored against an instruction-length CPU model.
module tb_cpu_step_sequencer;
    import step_pkg::*;
    localparam int D = 4;
    logic clk24 = 1'b0;
    logic reset = 1'b1;
    always #5 clk24 = ~clk24;

    cpu_step_sequencer_if #(.CNT_W(8)) bus();
    cpu_step_sequencer #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (.clk24(clk24), .reset(reset), .bus(bus));

    typedef struct {bit se, si, m1, ce, exp_ce, exp_halt;} vec_t;
    vec_t vec [8];
    int checks = 0, errors = 0, grants = 0, presses = 0;
    int ilen [0:4095];
    int idx = 0, tpos = 0;
    logic [15:0] pc = 16'h00F0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_cpu();
        bus.cpu_m1 = (tpos == 0);
`ifdef STEP_BREAKPOINT_EN
        bus.cpu_addr = pc;
`endif
    endtask

    // one clock: CPU model advances only on slots the DUT grants
    task automatic tick_o(input bit ce, output bit got);
        bus.ce_slot = ce;
        drive_cpu();
        @(negedge clk24);
        got = bus.cpu_ce;
        presses += int'(dut.u_deb.press_o);
        if (ce && got) begin
            grants++;
            tpos++;
            if (tpos == ilen[idx]) begin
                tpos = 0;
                pc += 16'(ilen[idx]);
                idx++;
            end
        end
        @(posedge clk24);
        #1;
        bus.ce_slot = 1'b0;
        drive_cpu();
    endtask

    task automatic tick(input bit ce);
        bit g;
        tick_o(ce, g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.step_enabled = 1'b0;
        bus.step_instr = 1'b0;
        bus.n_key = 1'b1;
        bus.burst_len = 8'd1;
        bus.ce_slot = 1'b0;
`ifdef STEP_BREAKPOINT_EN
        bus.bp_enable = 1'b0;
        bus.bp_addr = 16'h0100;
`endif
        tpos = 0;
        idx++;
        pc = 16'h00F0;
        drive_cpu();
        repeat (2) @(posedge clk24);
        #1;
        reset = 1'b0;
    endtask

    task automatic press_key();
        bus.n_key = 1'b0;
        repeat (8) tick(1'b0);
        bus.n_key = 1'b1;
        repeat (8) tick(1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit g;
        int base, n, exp, b;
        for (int i = 0; i < 4096; i++) ilen[i] = 1 + int'($urandom % 6);
        vec[0] = '{0, 0, 0, 1, 1, 0};
        vec[1] = '{0, 1, 1, 1, 1, 0};
        vec[2] = '{1, 0, 0, 1, 1, 1};
        vec[3] = '{1, 0, 1, 0, 0, 1};
        vec[4] = '{1, 1, 0, 1, 1, 0};
        vec[5] = '{1, 1, 1, 1, 0, 1};
        vec[6] = '{1, 1, 1, 0, 0, 0};
        vec[7] = '{0, 0, 1, 0, 0, 0};

        // reset state, cpu_ce forced low during the reset cycle
        do_reset();
        reset = 1'b1;
        bus.ce_slot = 1'b1;
        @(negedge clk24);
        chk("reset_cpu_ce", bus.cpu_ce, 0);
        @(posedge clk24);
        #1;
        chk("reset_halted", bus.halted, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_steps", bus.steps_left, 0);
        reset = 1'b0;
        bus.ce_slot = 1'b0;

        // RUN-state grant and transition table
        foreach (vec[i]) begin
            do_reset();
            bus.step_enabled = vec[i].se;
            bus.step_instr = vec[i].si;
            bus.cpu_m1 = vec[i].m1;
            bus.ce_slot = vec[i].ce;
            @(negedge clk24);
            chk($sformatf("vec%0d_ce", i), bus.cpu_ce, vec[i].exp_ce);
            @(posedge clk24);
            #1;
            chk($sformatf("vec%0d_halted", i), bus.halted, vec[i].exp_halt);
            bus.ce_slot = 1'b0;
        end

        // free run
        do_reset();
        for (int i = 0; i < 100; i++) begin
            tick_o(i % 8 == 0, g);
            chk("freerun_ce", g, int'(i % 8 == 0));
        end
        chk("freerun_halted", bus.halted, 0);

        // T-state burst of 3 with the key held afterwards
        bus.step_enabled = 1'b1;
        tick(1'b0);
        chk("tburst_idle", bus.halted, 1);
        bus.burst_len = 8'd3;
        bus.n_key = 1'b0;
        repeat (8) tick(1'b0);
        chk("tburst_busy", bus.busy, 1);
        chk("tburst_loaded", bus.steps_left, 3);
        grants = 0;
        for (int i = 0; i < 60; i++) tick(i % 3 == 0);
        chk("tburst_grants", grants, 3);
        chk("tburst_halted", bus.halted, 1);
        chk("tburst_steps", bus.steps_left, 0);
        bus.n_key = 1'b1;
        repeat (8) tick(1'b0);

        // burst_len 0 acts as 1
        bus.burst_len = 8'd0;
        press_key();
        chk("b0_loaded", bus.steps_left, 1);
        grants = 0;
        for (int i = 0; i < 20; i++) tick(i % 2 == 0);
        chk("b0_grants", grants, 1);

        // instruction step: lengths 4 and 7, mode change mid-burst ignored
        do_reset();
        ilen[idx] = 4;
        ilen[idx + 1] = 7;
        ilen[idx + 2] = 5;
        base = idx;
        bus.step_enabled = 1'b1;
        bus.step_instr = 1'b1;
        tick(1'b1);
        chk("instr_first_m1_held", bus.halted, 1);
        bus.burst_len = 8'd2;
        press_key();
        bus.step_instr = 1'b0;
        grants = 0;
        for (int i = 0; i < 60; i++) tick(i % 2 == 0);
        chk("instr_grants", grants, 11);
        chk("instr_halted", bus.halted, 1);
        chk("instr_at_m1", tpos, 0);
        chk("instr_idx", idx - base, 2);

        // debounce through 2-cycle glitches, one press 5 cycles after final edge
        do_reset();
        presses = 0;
        for (int i = 0; i < 20; i++) begin
            bus.n_key = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick(1'b0);
        end
        chk("glitch_no_press", presses, 0);
        bus.n_key = 1'b0;
        repeat (4) tick(1'b0);
        chk("deb_early", dut.u_deb.press_o, 0);
        tick(1'b0);
        chk("deb_on_time", dut.u_deb.press_o, 1);
        repeat (10) tick(1'b0);
        chk("deb_one_press", presses, 1);
        bus.n_key = 1'b1;
        repeat (10) tick(1'b0);
        chk("deb_release", presses, 1);

        // abort a long burst
        do_reset();
        bus.step_enabled = 1'b1;
        tick(1'b0);
        bus.burst_len = 8'd200;
        press_key();
        grants = 0;
        for (int i = 0; i < 100 && grants < 5; i++) tick(i % 2 == 0);
        chk("abort_grants", grants, 5);
        chk("abort_steps_mid", bus.steps_left, 195);
        bus.step_enabled = 1'b0;
        tick(1'b0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_halted", bus.halted, 0);
        chk("abort_steps", bus.steps_left, 0);
        for (int i = 0; i < 20; i++) begin
            tick_o(i % 3 == 0, g);
            chk("abort_run_ce", g, int'(i % 3 == 0));
        end

        // randomized bursts against the instruction-length model
        do_reset();
        bus.step_enabled = 1'b1;
        tick(1'b0);
        for (int r = 0; r < 40; r++) begin
            bus.step_instr = 1'($urandom % 2);
            b = int'($urandom % 5);
            bus.burst_len = 8'(b);
            n = (b == 0) ? 1 : b;
            if (bus.step_instr) begin
                exp = ilen[idx] - tpos;
                for (int k = 1; k < n; k++) exp += ilen[idx + k];
            end else exp = n;
            press_key();
            grants = 0;
            for (int i = 0; i < 600 && !bus.halted; i++) tick($urandom % 3 == 0);
            chk("rand_grants", grants, exp);
            chk("rand_halted", bus.halted, 1);
            chk("rand_steps", bus.steps_left, 0);
            if (bus.step_instr) chk("rand_at_m1", tpos, 0);
        end

`ifdef STEP_BREAKPOINT_EN
        // breakpoint at 0x0100, then step past it
        do_reset();
        for (int k = 0; k < 8; k++) ilen[idx + k] = 4;
        bus.bp_enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(i % 2 == 0);
            if (bus.halted) begin
                bus.step_enabled = 1'b1;
                break;
            end
        end
        chk("bp_halted", bus.halted, 1);
        chk("bp_hit", bus.bp_hit, 1);
        chk("bp_pc", pc, 16'h0100);
        chk("bp_at_m1", tpos, 0);
        bus.step_instr = 1'b1;
        bus.burst_len = 8'd1;
        press_key();
        chk("bp_cleared", bus.bp_hit, 0);
        grants = 0;
        for (int i = 0; i < 30; i++) tick(i % 2 == 0);
        chk("bp_step_grants", grants, 4);
        chk("bp_step_pc", pc, 16'h0104);
        chk("bp_step_halted", bus.halted, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
